// File: rtl/riscv_harness_pkg.sv
// Shared types and constants for the core run controller and its halt tracker.
// The pass code follows the tohost convention: 1 means the hart passed.
package riscv_harness_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESET = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } run_state_e;

  localparam logic [31:0] PASS_CODE = 32'd1;

  // Width of the failing-hart index; one spare bit leaves room for the all-ones "none" value.
  function automatic int unsigned fail_idx_width(input int unsigned num_harts);
    return $clog2(num_harts) + 1;
  endfunction

endpackage

// File: rtl/hart_halt_tracker.sv
// Tracks which harts have reported a halt during a run and picks the
// lowest-index hart whose new report carries a non-pass code.
module hart_halt_tracker
  import riscv_harness_pkg::*;
#(
  parameter int NUM_HARTS = 1,
  parameter int CODE_W    = 32,
  parameter int FH_W      = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        enable,
  input  logic [NUM_HARTS-1:0]        halt_valid,
  input  logic [NUM_HARTS*CODE_W-1:0] halt_code,
  output logic                        all_halted,
  output logic                        any_fail,
  output logic [FH_W-1:0]             fail_idx,
  output logic [CODE_W-1:0]           fail_code
);

  logic [NUM_HARTS-1:0] mask_q;
  logic [NUM_HARTS-1:0] mask_d;
  logic [NUM_HARTS-1:0] new_halt_s;
  logic [NUM_HARTS-1:0] fail_vec_s;
  logic                 found_s;

  // Only first reports from not-yet-halted harts count, and only while running.
  always_comb begin
    new_halt_s = {NUM_HARTS{1'b0}};
    fail_vec_s = {NUM_HARTS{1'b0}};
    if (enable) begin
      new_halt_s = halt_valid & ~mask_q;
    end else begin
      new_halt_s = {NUM_HARTS{1'b0}};
    end
    for (int i = 0; i < NUM_HARTS; i++) begin
      fail_vec_s[i] = new_halt_s[i] && (halt_code[i*CODE_W +: CODE_W] != CODE_W'(PASS_CODE));
    end
    mask_d     = mask_q | new_halt_s;
    all_halted = &mask_d;
    any_fail   = |fail_vec_s;
  end

  // Priority encoder: the lowest failing index wins when several fail together.
  always_comb begin
    fail_idx  = {FH_W{1'b1}};
    fail_code = {CODE_W{1'b0}};
    found_s   = 1'b0;
    for (int i = 0; i < NUM_HARTS; i++) begin
      if (fail_vec_s[i] && !found_s) begin
        fail_idx  = FH_W'(i);
        fail_code = halt_code[i*CODE_W +: CODE_W];
        found_s   = 1'b1;
      end else begin
        found_s   = found_s;
      end
    end
  end

  // Halted-mask register, cleared at the start of every run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= {NUM_HARTS{1'b0}};
    end else if (clear) begin
      mask_q <= {NUM_HARTS{1'b0}};
    end else begin
      mask_q <= mask_d;
    end
  end

endmodule

// File: rtl/core_run_ctrl.sv
// Run controller for the core harness: sequences core reset, counts run cycles
// and closes each run as pass, fail (halt code or abort) or timeout.
module core_run_ctrl
  import riscv_harness_pkg::*;
#(
  parameter int NUM_HARTS    = 1,
  parameter int RESET_CYCLES = 2,
  parameter int MAX_CYCLES   = 500,
  parameter int CNT_W        = 32,
  parameter int CODE_W       = 32,
  localparam int FH_W        = fail_idx_width(NUM_HARTS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [NUM_HARTS-1:0]        halt_valid,
  input  logic [NUM_HARTS*CODE_W-1:0] halt_code,
  output logic                        core_rst,
  output logic                        running,
  output logic                        done,
  output logic                        pass,
  output logic                        timeout,
  output logic [FH_W-1:0]             fail_hart,
  output logic [CODE_W-1:0]           fail_code,
  output logic [CNT_W-1:0]            cycle_count
);

  localparam int RC_W = $clog2(RESET_CYCLES + 1);

  run_state_e        state_q, state_d;
  logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic              core_rst_q, core_rst_d;
  logic              running_q, running_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              timeout_q, timeout_d;
  logic [FH_W-1:0]   fail_hart_q, fail_hart_d;
  logic [CODE_W-1:0] fail_code_q, fail_code_d;

  logic              start_run_s;
  logic              in_run_s;
  logic              all_halted_s;
  logic              any_fail_s;
  logic [FH_W-1:0]   fail_idx_s;
  logic [CODE_W-1:0] fail_val_s;

  assign start_run_s = start && ((state_q == IDLE) || (state_q == DONE));
  assign in_run_s    = (state_q == RUN);

  hart_halt_tracker #(
    .NUM_HARTS (NUM_HARTS),
    .CODE_W    (CODE_W),
    .FH_W      (FH_W)
  ) u_tracker (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (start_run_s),
    .enable     (in_run_s),
    .halt_valid (halt_valid),
    .halt_code  (halt_code),
    .all_halted (all_halted_s),
    .any_fail   (any_fail_s),
    .fail_idx   (fail_idx_s),
    .fail_code  (fail_val_s)
  );

  // Next state, counters and result capture; outputs derive from the next state.
  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    cycle_d     = cycle_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    fail_hart_d = fail_hart_q;
    fail_code_d = fail_code_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_run_s) begin
          state_d     = RESET;
          rst_cnt_d   = {RC_W{1'b0}};
          cycle_d     = {CNT_W{1'b0}};
          pass_d      = 1'b0;
          timeout_d   = 1'b0;
          fail_hart_d = {FH_W{1'b1}};
          fail_code_d = {CODE_W{1'b0}};
        end else begin
          state_d = state_q;
        end
      end
      RESET: begin
        if (abort) begin
          state_d = DONE;
        end else if (rst_cnt_q == RC_W'(RESET_CYCLES - 1)) begin
          state_d = RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + {{(RC_W-1){1'b0}}, 1'b1};
        end
      end
      RUN: begin
        if (cycle_q == {CNT_W{1'b1}}) begin
          cycle_d = cycle_q;
        end else begin
          cycle_d = cycle_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        // Termination priority: abort, failing halt, all halted, budget exhausted.
        if (abort) begin
          state_d     = DONE;
          pass_d      = 1'b0;
          timeout_d   = 1'b0;
          fail_hart_d = {FH_W{1'b1}};
          fail_code_d = {CODE_W{1'b0}};
        end else if (any_fail_s) begin
          state_d     = DONE;
          pass_d      = 1'b0;
          fail_hart_d = fail_idx_s;
          fail_code_d = fail_val_s;
        end else if (all_halted_s) begin
          state_d = DONE;
          pass_d  = 1'b1;
        end else if (cycle_q == CNT_W'(MAX_CYCLES - 1)) begin
          state_d   = DONE;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    core_rst_d = (state_d != RUN);
    running_d  = (state_d == RUN);
    done_d     = (state_d == DONE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rst_cnt_q   <= {RC_W{1'b0}};
      cycle_q     <= {CNT_W{1'b0}};
      core_rst_q  <= 1'b1;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      fail_hart_q <= {FH_W{1'b1}};
      fail_code_q <= {CODE_W{1'b0}};
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      cycle_q     <= cycle_d;
      core_rst_q  <= core_rst_d;
      running_q   <= running_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      fail_hart_q <= fail_hart_d;
      fail_code_q <= fail_code_d;
    end
  end

  assign core_rst    = core_rst_q;
  assign running     = running_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign fail_hart   = fail_hart_q;
  assign fail_code   = fail_code_q;
  assign cycle_count = cycle_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Self-checking bench for core_run_ctrl: a single-hart and a four-hart instance,
// with expected run results queued at stimulus time and checked when done rises.
module tb_core_run_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Single-hart instance, default budget of 500 cycles.
  logic        rst1_n, start1, abort1, hv1;
  logic [31:0] hc1;
  logic        cr1, run1, done1, pass1, to1, fh1;
  logic [31:0] fc1, cc1;

  // Four-hart instance with a short budget of 40 cycles.
  logic         rst4_n, start4, abort4;
  logic [3:0]   hv4;
  logic [127:0] hc4;
  logic         cr4, run4, done4, pass4, to4;
  logic [2:0]   fh4;
  logic [31:0]  fc4, cc4;

  core_run_ctrl #(.NUM_HARTS(1)) u_dut1 (
    .clk(clk), .rst_n(rst1_n), .start(start1), .abort(abort1),
    .halt_valid(hv1), .halt_code(hc1), .core_rst(cr1), .running(run1),
    .done(done1), .pass(pass1), .timeout(to1), .fail_hart(fh1),
    .fail_code(fc1), .cycle_count(cc1)
  );

  core_run_ctrl #(.NUM_HARTS(4), .MAX_CYCLES(40)) u_dut4 (
    .clk(clk), .rst_n(rst4_n), .start(start4), .abort(abort4),
    .halt_valid(hv4), .halt_code(hc4), .core_rst(cr4), .running(run4),
    .done(done4), .pass(pass4), .timeout(to4), .fail_hart(fh4),
    .fail_code(fc4), .cycle_count(cc4)
  );

  typedef struct {
    string       tag;
    logic        pass;
    logic        timeout;
    logic [31:0] fh;
    logic [31:0] fc;
    logic [31:0] cc;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic p, input logic t,
                          input logic [31:0] fh, input logic [31:0] fc, input logic [31:0] cc);
    exp_t e;
    e.tag = tag; e.pass = p; e.timeout = t; e.fh = fh; e.fc = fc; e.cc = cc;
    exp_q.push_back(e);
  endtask

  task automatic set_code4(input int h, input logic [31:0] c);
    hc4[h*32 +: 32] = c;
  endtask

  // Wait (bounded) for done on the chosen instance, then score its results.
  task automatic finish_run(input int which, input int budget);
    int   n;
    exp_t e;
    n = 0;
    while (!(which == 1 ? done1 : done4) && n < budget) begin
      tick();
      n++;
    end
    check_eq("done_seen", {31'd0, (which == 1 ? done1 : done4)}, 32'd1);
    if (exp_q.size() == 0) begin
      check_eq("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      if (which == 1) begin
        check_eq({e.tag, "_pass"}, {31'd0, pass1}, {31'd0, e.pass});
        check_eq({e.tag, "_timeout"}, {31'd0, to1}, {31'd0, e.timeout});
        check_eq({e.tag, "_fail_hart"}, {31'd0, fh1}, e.fh);
        check_eq({e.tag, "_fail_code"}, fc1, e.fc);
        check_eq({e.tag, "_cycles"}, cc1, e.cc);
        check_eq({e.tag, "_core_rst"}, {31'd0, cr1}, 32'd1);
      end else begin
        check_eq({e.tag, "_pass"}, {31'd0, pass4}, {31'd0, e.pass});
        check_eq({e.tag, "_timeout"}, {31'd0, to4}, {31'd0, e.timeout});
        check_eq({e.tag, "_fail_hart"}, {29'd0, fh4}, e.fh);
        check_eq({e.tag, "_fail_code"}, fc4, e.fc);
        check_eq({e.tag, "_cycles"}, cc4, e.cc);
        check_eq({e.tag, "_core_rst"}, {31'd0, cr4}, 32'd1);
      end
    end
  endtask

  task automatic start4_to_run();
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    rst1_n = 1'b0; start1 = 1'b0; abort1 = 1'b0; hv1 = 1'b0; hc1 = 32'd0;
    rst4_n = 1'b0; start4 = 1'b0; abort4 = 1'b0; hv4 = 4'd0; hc4 = 128'd0;
    tick();
    tick();
    check_eq("rst_core_rst", {31'd0, cr1}, 32'd1);
    check_eq("rst_running", {31'd0, run1}, 32'd0);
    check_eq("rst_done", {31'd0, done4}, 32'd0);
    check_eq("rst_fail_hart1", {31'd0, fh1}, 32'd1);
    check_eq("rst_fail_hart4", {29'd0, fh4}, 32'd7);
    check_eq("rst_cycles", cc4, 32'd0);
    rst1_n = 1'b1;
    rst4_n = 1'b1;
    tick();

    // Single hart: reset sequencing, start ignored mid-run, pass at run cycle 10.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check_eq("t1_rst_a", {31'd0, cr1}, 32'd1);
    tick();
    check_eq("t1_rst_b", {31'd0, cr1}, 32'd1);
    check_eq("t1_not_running", {31'd0, run1}, 32'd0);
    tick();
    check_eq("t1_core_rst_low", {31'd0, cr1}, 32'd0);
    check_eq("t1_running", {31'd0, run1}, 32'd1);
    check_eq("t1_cnt0", cc1, 32'd0);
    repeat (5) tick();
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (4) tick();
    check_eq("t1_cnt10", cc1, 32'd10);
    hv1 = 1'b1; hc1 = 32'd1;
    push_exp("t1", 1'b1, 1'b0, 32'd1, 32'd0, 32'd11);
    tick();
    hv1 = 1'b0; hc1 = 32'd0;
    finish_run(1, 0);
    abort1 = 1'b1;
    tick();
    abort1 = 1'b0;
    check_eq("abort_in_done_done", {31'd0, done1}, 32'd1);
    check_eq("abort_in_done_pass", {31'd0, pass1}, 32'd1);

    // Single hart: timeout after the full budget.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    push_exp("t2", 1'b0, 1'b1, 32'd1, 32'd0, 32'd500);
    finish_run(1, 600);

    // Single hart: asynchronous reset mid-run, then a clean re-run.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    tick();
    repeat (50) tick();
    check_eq("t6_cnt50", cc1, 32'd50);
    #2 rst1_n = 1'b0;
    #1;
    check_eq("t6_core_rst", {31'd0, cr1}, 32'd1);
    check_eq("t6_running", {31'd0, run1}, 32'd0);
    check_eq("t6_cycles", cc1, 32'd0);
    check_eq("t6_fail_hart", {31'd0, fh1}, 32'd1);
    tick();
    rst1_n = 1'b1;
    tick();
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    tick();
    repeat (3) tick();
    hv1 = 1'b1; hc1 = 32'd1;
    push_exp("t6_rerun", 1'b1, 1'b0, 32'd1, 32'd0, 32'd4);
    tick();
    hv1 = 1'b0; hc1 = 32'd0;
    finish_run(1, 0);

    // Four harts: halts during reset ignored; hart 1 fails after the rest pass.
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    hv4 = 4'hF;
    for (int h = 0; h < 4; h++) set_code4(h, 32'h55);
    tick();
    hv4 = 4'h0;
    tick();
    check_eq("t3_running", {31'd0, run4}, 32'd1);
    check_eq("t3_cnt0", cc4, 32'd0);
    repeat (3) tick();
    hv4 = 4'b0101; set_code4(0, 32'd1); set_code4(2, 32'd1);
    tick();
    hv4 = 4'b1001; set_code4(0, 32'h99); set_code4(3, 32'd1);
    tick();
    hv4 = 4'b0010; set_code4(1, 32'h55);
    push_exp("t3", 1'b0, 1'b0, 32'd1, 32'h55, 32'd6);
    tick();
    hv4 = 4'h0;
    finish_run(4, 0);

    // Four harts: last halts land on the final budget cycle, pass beats timeout.
    for (int h = 0; h < 4; h++) set_code4(h, 32'd1);
    start4_to_run();
    repeat (5) tick();
    hv4 = 4'b1100;
    tick();
    hv4 = 4'h0;
    repeat (33) tick();
    check_eq("t4a_cnt39", cc4, 32'd39);
    hv4 = 4'b0011;
    push_exp("t4a", 1'b1, 1'b0, 32'd7, 32'd0, 32'd40);
    tick();
    hv4 = 4'h0;
    finish_run(4, 0);

    // Four harts: simultaneous failures record the lowest index.
    start4_to_run();
    repeat (2) tick();
    hv4 = 4'b1011;
    set_code4(0, 32'h11); set_code4(1, 32'h22); set_code4(3, 32'h33);
    push_exp("t4b", 1'b0, 1'b0, 32'd0, 32'h11, 32'd3);
    tick();
    hv4 = 4'h0;
    finish_run(4, 0);

    // Four harts: abort in reset, then a clean passing re-run.
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    abort4 = 1'b1;
    push_exp("t5_abort", 1'b0, 1'b0, 32'd7, 32'd0, 32'd0);
    tick();
    abort4 = 1'b0;
    finish_run(4, 0);
    for (int h = 0; h < 4; h++) set_code4(h, 32'd1);
    start4_to_run();
    repeat (4) tick();
    hv4 = 4'hF;
    push_exp("t5_rerun", 1'b1, 1'b0, 32'd7, 32'd0, 32'd5);
    tick();
    hv4 = 4'h0;
    finish_run(4, 0);

    // Four harts: abort in run outranks a same-cycle failing halt.
    start4_to_run();
    repeat (3) tick();
    abort4 = 1'b1;
    hv4 = 4'b0001; set_code4(0, 32'h77);
    push_exp("abort_run", 1'b0, 1'b0, 32'd7, 32'd0, 32'd4);
    tick();
    abort4 = 1'b0;
    hv4 = 4'h0;
    finish_run(4, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/core_run_ctrl.md
Name: core_run_ctrl

Overview:
Synthesizable run controller for the core simulation and FPGA harness, replacing fixed testbench delays. It sequences core reset, counts run cycles, collects per-hart halt reports (tohost-style codes) and closes the run with pass, fail or timeout. It sits between the harness top and one or more core instances, driving their reset and observing their halt ports.

Parameters:
NUM_HARTS, 1, number of observed cores (1..8)
RESET_CYCLES, 2, cycles core_rst is held after start (>=1)
MAX_CYCLES, 500, run-cycle budget before timeout (>=1)
CNT_W, 32, cycle counter width; MAX_CYCLES must fit in CNT_W bits
CODE_W, 32, width of halt code

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a run from IDLE or DONE
abort  in  1  forces end of run as fail
halt_valid  in  NUM_HARTS  per-hart halt report strobe
halt_code  in  NUM_HARTS*CODE_W  per-hart code; hart i at bits [i*CODE_W +: CODE_W]
core_rst  out  1  active-high reset to cores
running  out  1  high in RUN
done  out  1  high in DONE
pass  out  1  valid when done
timeout  out  1  valid when done
fail_hart  out  $clog2(NUM_HARTS)+1 (min 1)  index of first failing hart; all-ones if none
fail_code  out  CODE_W  code of first failing hart; 0 if none
cycle_count  out  CNT_W  RUN cycles elapsed

Behaviour:
- Async reset (rst_n=0): state IDLE; core_rst=1; running=0, done=0, pass=0, timeout=0; fail_hart=all-ones; fail_code=0; cycle_count=0; halted mask=0.
- States: IDLE, RESET, RUN, DONE. All outputs registered.
- IDLE: core_rst=1. start -> RESET; rst counter=0; cycle_count, mask, results cleared.
- RESET: core_rst=1 for exactly RESET_CYCLES cycles, then RUN. core_rst deasserts on the first RUN cycle.
- RUN: cycle_count increments every cycle, saturating at all-ones. halt_valid[i]=1 sets mask bit i; repeated reports from an already-halted hart are ignored.
- Pass code is 1. halt_code[i]!=1 on a new report: fail_hart=i, fail_code=code, -> DONE, pass=0. When several harts fail in the same cycle, the lowest index is recorded.
- When all mask bits are set with no failure (including bits set in the current cycle): -> DONE, pass=1.
- Timeout: when cycle_count==MAX_CYCLES-1 and no terminating halt occurs in that cycle -> DONE, timeout=1, pass=0. A run therefore lasts at most MAX_CYCLES cycles.
- Precedence in a single cycle: abort > failing halt > all-halted pass > timeout.
- abort in RESET or RUN: -> DONE, pass=0, timeout=0, fail_hart=all-ones.
- abort in IDLE or DONE is ignored.
- DONE: core_rst=1 (cores frozen), done=1. Results and cycle_count hold. start -> RESET (re-run clears results).
- start while in RESET or RUN is ignored.
- halt_valid outside RUN is ignored.
- rst_n assertion mid-run: immediate return to IDLE; core_rst=1 asynchronously.

Decomposition:
- Package riscv_harness_pkg: run_state_e enum (IDLE, RESET, RUN, DONE); PASS_CODE=32'd1 constant.
- Sub-module hart_halt_tracker: collects the halted mask and picks the lowest-index failing hart (priority encoder). It is instantiated once.
- All other logic (FSM, counters) lives in core_run_ctrl.

Test Plan:
1. NUM_HARTS=1, RESET_CYCLES=2: start at cycle 0 -> core_rst high for 2 cycles after start, then running=1; halt_valid with code 1 at run cycle 10 -> next cycle done=1, pass=1, cycle_count=11.
2. MAX_CYCLES=500, no halts -> done at cycle_count=500, timeout=1, pass=0, core_rst=1.
3. NUM_HARTS=4: harts 0,2,3 halt with code 1; hart 1 halts with code 0x55 -> done, pass=0, fail_hart=1, fail_code=0x55.
4. NUM_HARTS=2: both harts halt with code 1 in the same cycle that cycle_count=MAX_CYCLES-1 -> pass=1, timeout=0. Separately, harts 0 and 1 fail in the same cycle -> fail_hart=0.
5. abort during RESET -> DONE with pass=0, timeout=0. Then start -> new run with cleared results; hart halt with code 1 -> pass=1.
6. rst_n pulsed low mid-RUN at cycle 50 -> core_rst=1 immediately, all outputs at reset values; start afterwards runs normally.
